issue_operand_stage: RTL and testbench

- Register-read stage directly downstream of the in-order reservation station.
- Accepts one issued micro-op per cycle and reads both source operands from the physical register file.
- Overrides stale register-file data with same-cycle writeback bypass.
- Buffers the operand-complete micro-op in a 2-entry elastic queue feeding the execution unit, so the RS never sees a combinational path from ex_ready_i.

---
 rtl/issue_operand_stage.sv | 158 +++++++++++++++
 tb/tb_issue_operand_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_operand_stage.sv
// Register-read stage between the in-order reservation station and the
// execution unit. Each issued micro-op reads both source operands from the
// physical register file (with same-cycle writeback bypass taking priority)
// and is parked in a 2-entry elastic queue. Because is_ready_o comes only
// from the registered occupancy, the RS never sees a combinational path
// from ex_ready_i.
//
// Handshake: on both sides a transfer happens on a clock edge where valid
// and ready are both high. A producer keeps valid and its payload stable
// until that edge. ready never depends on valid from the same interface.
module issue_operand_stage #(
  parameter int WB_WIDTH    = 4,
  parameter int PHY_REG_NUM = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int OC_WIDTH    = 16,
  localparam int PW         = $clog2(PHY_REG_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  // issue side
  input  logic                           is_valid_i,
  output logic                           is_ready_o,
  input  logic [PW-1:0]                  is_psrc0_i,
  input  logic                           is_psrc0_valid_i,
  input  logic [PW-1:0]                  is_psrc1_i,
  input  logic                           is_psrc1_valid_i,
  input  logic [PW-1:0]                  is_pdest_i,
  input  logic                           is_pdest_valid_i,
  input  logic [OC_WIDTH-1:0]            is_oc_i,
  // register file read ports
  output logic [PW-1:0]                  rf_raddr0_o,
  output logic [PW-1:0]                  rf_raddr1_o,
  input  logic [DATA_WIDTH-1:0]          rf_rdata0_i,
  input  logic [DATA_WIDTH-1:0]          rf_rdata1_i,
  // writeback bypass
  input  logic [WB_WIDTH-1:0]            wb_i,
  input  logic [WB_WIDTH*PW-1:0]         wb_pdest_i,
  input  logic [WB_WIDTH*DATA_WIDTH-1:0] wb_data_i,
  // execution side
  output logic                           ex_valid_o,
  input  logic                           ex_ready_i,
  output logic [DATA_WIDTH-1:0]          ex_src0_o,
  output logic [DATA_WIDTH-1:0]          ex_src1_o,
  output logic [PW-1:0]                  ex_pdest_o,
  output logic                           ex_pdest_valid_o,
  output logic [OC_WIDTH-1:0]            ex_oc_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] src0;
    logic [DATA_WIDTH-1:0] src1;
    logic [PW-1:0]         pdest;
    logic                  pdest_valid;
    logic [OC_WIDTH-1:0]   oc;
  } entry_t;

  entry_t      entry_q [2];
  entry_t      entry_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        push, pop;

  // Operand select: unused source reads zero; otherwise the lowest-index
  // matching writeback port wins over the register file.
  function automatic logic [DATA_WIDTH-1:0] sel_operand(
    input logic [PW-1:0]                  psrc,
    input logic                           used,
    input logic [DATA_WIDTH-1:0]          rf,
    input logic [WB_WIDTH-1:0]            wb_v,
    input logic [WB_WIDTH*PW-1:0]         wb_pd,
    input logic [WB_WIDTH*DATA_WIDTH-1:0] wb_dt
  );
    logic [DATA_WIDTH-1:0] r;
    r = rf;
    // Scan high to low so the lowest matching index is the last assignment.
    for (int j = WB_WIDTH - 1; j >= 0; j--) begin
      if (wb_v[j] && (wb_pd[j*PW +: PW] == psrc)) begin
        r = wb_dt[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (!used) begin
      r = '0;
    end
    return r;
  endfunction

  assign rf_raddr0_o = is_psrc0_i;
  assign rf_raddr1_o = is_psrc1_i;

  assign is_ready_o = (count_q != 2'd2);
  assign ex_valid_o = (count_q != 2'd0);
  assign push       = is_valid_i && is_ready_o;
  assign pop        = ex_valid_o && ex_ready_i;

  assign ex_src0_o        = entry_q[rd_ptr_q].src0;
  assign ex_src1_o        = entry_q[rd_ptr_q].src1;
  assign ex_pdest_o       = entry_q[rd_ptr_q].pdest;
  assign ex_pdest_valid_o = entry_q[rd_ptr_q].pdest_valid;
  assign ex_oc_o          = entry_q[rd_ptr_q].oc;

  // Build the entry captured on push; operands are frozen at this point.
  always_comb begin
    entry_d             = '0;
    entry_d.src0        = sel_operand(is_psrc0_i, is_psrc0_valid_i, rf_rdata0_i,
                                      wb_i, wb_pdest_i, wb_data_i);
    entry_d.src1        = sel_operand(is_psrc1_i, is_psrc1_valid_i, rf_rdata1_i,
                                      wb_i, wb_pdest_i, wb_data_i);
    entry_d.pdest       = is_pdest_i;
    entry_d.pdest_valid = is_pdest_valid_i;
    entry_d.oc          = is_oc_i;
  end

  // Next-state for pointers and occupancy; flush discards any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; payloads are cleared only by reset, never by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else if (push && !flush_i) begin
      entry_q[wr_ptr_q] <= entry_d;
    end
  end

endmodule

// File: tb/tb_issue_operand_stage.sv
// Directed bench for issue_operand_stage. Inputs change and outputs are
// sampled on the falling edge; the DUT captures on the rising edge.
module tb_issue_operand_stage;
  localparam int PW = 6;
  localparam int DW = 32;
  localparam int OW = 16;
  localparam int NW = 4;

  logic              clk, rst_n, flush_i;
  logic              is_valid_i, is_ready_o;
  logic [PW-1:0]     is_psrc0_i, is_psrc1_i, is_pdest_i;
  logic              is_psrc0_valid_i, is_psrc1_valid_i, is_pdest_valid_i;
  logic [OW-1:0]     is_oc_i;
  logic [PW-1:0]     rf_raddr0_o, rf_raddr1_o;
  logic [DW-1:0]     rf_rdata0_i, rf_rdata1_i;
  logic [NW-1:0]     wb_i;
  logic [NW*PW-1:0]  wb_pdest_i;
  logic [NW*DW-1:0]  wb_data_i;
  logic              ex_valid_o, ex_ready_i, ex_pdest_valid_o;
  logic [DW-1:0]     ex_src0_o, ex_src1_o;
  logic [PW-1:0]     ex_pdest_o;
  logic [OW-1:0]     ex_oc_o;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  issue_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .is_valid_i(is_valid_i), .is_ready_o(is_ready_o),
    .is_psrc0_i(is_psrc0_i), .is_psrc0_valid_i(is_psrc0_valid_i),
    .is_psrc1_i(is_psrc1_i), .is_psrc1_valid_i(is_psrc1_valid_i),
    .is_pdest_i(is_pdest_i), .is_pdest_valid_i(is_pdest_valid_i),
    .is_oc_i(is_oc_i),
    .rf_raddr0_o(rf_raddr0_o), .rf_raddr1_o(rf_raddr1_o),
    .rf_rdata0_i(rf_rdata0_i), .rf_rdata1_i(rf_rdata1_i),
    .wb_i(wb_i), .wb_pdest_i(wb_pdest_i), .wb_data_i(wb_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_src0_o(ex_src0_o), .ex_src1_o(ex_src1_o),
    .ex_pdest_o(ex_pdest_o), .ex_pdest_valid_o(ex_pdest_valid_o),
    .ex_oc_o(ex_oc_o)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, checks=%0d required=finish", checks);
    $fatal(1);
  end

  // Advance one full cycle, landing on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_op(input logic v, input logic [PW-1:0] s0, input logic s0v,
                          input logic [PW-1:0] s1, input logic s1v,
                          input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                          input logic [PW-1:0] pd, input logic [OW-1:0] oc);
    is_valid_i = v;
    is_psrc0_i = s0; is_psrc0_valid_i = s0v;
    is_psrc1_i = s1; is_psrc1_valid_i = s1v;
    rf_rdata0_i = r0; rf_rdata1_i = r1;
    is_pdest_i = pd; is_pdest_valid_i = 1'b1;
    is_oc_i = oc;
  endtask

  task automatic set_wb(input int idx, input logic v, input logic [PW-1:0] pd,
                        input logic [DW-1:0] d);
    wb_i[idx] = v;
    wb_pdest_i[idx*PW +: PW] = pd;
    wb_data_i[idx*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b0;
    wb_i = '0; wb_pdest_i = '0; wb_data_i = '0;
    drive_op(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid_o); end
    checks++; if (is_ready_o !== 1'b1) begin errors++; $display("FAIL reset_is_ready got=%0b exp=1", is_ready_o); end
    checks++; if ({ex_src0_o, ex_src1_o} !== '0) begin errors++; $display("FAIL reset_srcs got=%h/%h exp=0", ex_src0_o, ex_src1_o); end
    checks++; if ({ex_pdest_o, ex_pdest_valid_o, ex_oc_o} !== '0) begin errors++; $display("FAIL reset_payload got=%h/%b/%h exp=0", ex_pdest_o, ex_pdest_valid_o, ex_oc_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    ex_ready_i = 1'b1;
    drive_op(1'b1, 6'd5, 1'b1, 6'd6, 1'b1, 32'h11, 32'h22, 6'd7, 16'h1234);
    checks++; if ({rf_raddr0_o, rf_raddr1_o} !== {6'd5, 6'd6}) begin errors++; $display("FAIL basic_raddr got=%0d/%0d exp=5/6", rf_raddr0_o, rf_raddr1_o); end
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL basic_no_comb_path got=%0b exp=0", ex_valid_o); end
    step();
    is_valid_i = 1'b0;
    checks++; if (ex_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", ex_valid_o); end
    checks++; if ({ex_src0_o, ex_src1_o} !== {32'h11, 32'h22}) begin errors++; $display("FAIL basic_srcs got=%h/%h exp=11/22", ex_src0_o, ex_src1_o); end
    checks++; if ({ex_pdest_o, ex_pdest_valid_o, ex_oc_o} !== {6'd7, 1'b1, 16'h1234}) begin errors++; $display("FAIL basic_payload got=%0d/%b/%h exp=7/1/1234", ex_pdest_o, ex_pdest_valid_o, ex_oc_o); end
    step();
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drain got=%0b exp=0", ex_valid_o); end
  endtask

  task automatic test_bypass();
    // Ports 1 and 2 both match psrc0=5: the lower index must win.
    ex_ready_i = 1'b0;
    set_wb(0, 1'b0, 6'd5, 32'h99);
    set_wb(1, 1'b1, 6'd5, 32'hAA);
    set_wb(2, 1'b1, 6'd5, 32'hBB);
    set_wb(3, 1'b0, 6'd5, 32'hCC);
    drive_op(1'b1, 6'd5, 1'b1, 6'd5, 1'b0, 32'h11, 32'h33, 6'd1, 16'h0001);
    step();
    is_valid_i = 1'b0;
    // New writeback to reg 5 after capture must not leak into the entry.
    set_wb(0, 1'b1, 6'd5, 32'hEE);
    checks++; if (ex_src0_o !== 32'hAA) begin errors++; $display("FAIL bypass_lowest got=%h exp=aa", ex_src0_o); end
    checks++; if (ex_src1_o !== 32'h0) begin errors++; $display("FAIL bypass_unused_src got=%h exp=0", ex_src1_o); end
    step();
    checks++; if (ex_src0_o !== 32'hAA) begin errors++; $display("FAIL bypass_no_resnoop got=%h exp=aa", ex_src0_o); end
    ex_ready_i = 1'b1;
    step();
    // Second vector: only port 3 matches src1; src0 has no match -> rf.
    wb_i = '0;
    set_wb(0, 1'b1, 6'd3, 32'h77);
    set_wb(3, 1'b1, 6'd9, 32'hDD);
    drive_op(1'b1, 6'd4, 1'b1, 6'd9, 1'b1, 32'h44, 32'h55, 6'd2, 16'h0002);
    step();
    is_valid_i = 1'b0; wb_i = '0;
    checks++; if ({ex_src0_o, ex_src1_o} !== {32'h44, 32'hDD}) begin errors++; $display("FAIL bypass_port3 got=%h/%h exp=44/dd", ex_src0_o, ex_src1_o); end
    step();
  endtask

  task automatic test_stall();
    ex_ready_i = 1'b0;
    drive_op(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'hA0, 32'hA1, 6'd10, 16'h000A);
    step();
    drive_op(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'hB0, 32'hB1, 6'd11, 16'h000B);
    checks++; if (is_ready_o !== 1'b1) begin errors++; $display("FAIL stall_ready_one got=%0b exp=1", is_ready_o); end
    step();
    drive_op(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'hC0, 32'hC1, 6'd12, 16'h000C);
    checks++; if (is_ready_o !== 1'b0) begin errors++; $display("FAIL stall_full got=%0b exp=0", is_ready_o); end
    checks++; if ({ex_src0_o, ex_oc_o} !== {32'hA0, 16'h000A}) begin errors++; $display("FAIL stall_head_a got=%h/%h exp=a0/000a", ex_src0_o, ex_oc_o); end
    step();
    checks++; if ({ex_valid_o, ex_src0_o, ex_src1_o, ex_pdest_o} !== {1'b1, 32'hA0, 32'hA1, 6'd10}) begin errors++; $display("FAIL stall_hold got=%b/%h/%h/%0d exp=1/a0/a1/10", ex_valid_o, ex_src0_o, ex_src1_o, ex_pdest_o); end
    checks++; if (is_ready_o !== 1'b0) begin errors++; $display("FAIL stall_still_full got=%0b exp=0", is_ready_o); end
    ex_ready_i = 1'b1;
    step();
    checks++; if ({ex_src0_o, ex_oc_o, is_ready_o} !== {32'hB0, 16'h000B, 1'b1}) begin errors++; $display("FAIL stall_head_b got=%h/%h/%b exp=b0/000b/1", ex_src0_o, ex_oc_o, is_ready_o); end
    step();
    is_valid_i = 1'b0;
    checks++; if ({ex_valid_o, ex_src0_o, ex_oc_o} !== {1'b1, 32'hC0, 16'h000C}) begin errors++; $display("FAIL stall_head_c got=%b/%h/%h exp=1/c0/000c", ex_valid_o, ex_src0_o, ex_oc_o); end
    step();
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL stall_drain got=%0b exp=0", ex_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    ex_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_op(1'b1, 6'd8, 1'b1, 6'd9, 1'b1, 32'h1000 + 32'(i * 3), 32'h0, 6'd0, 16'(i));
      exp_q.push_back(32'h1000 + 32'(i * 3));
      step();
      exp = exp_q.pop_front();
      checks++; if ({ex_valid_o, is_ready_o, ex_src0_o, ex_oc_o} !== {1'b1, 1'b1, exp, 16'(i)})
        begin errors++; $display("FAIL b2b_%0d got=%b/%b/%h/%h exp=1/1/%h/%h", i, ex_valid_o, is_ready_o, ex_src0_o, ex_oc_o, exp, 16'(i)); end
    end
    is_valid_i = 1'b0;
    step();
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0b exp=0", ex_valid_o); end
  endtask

  task automatic test_flush();
    ex_ready_i = 1'b0;
    drive_op(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'hD0, 32'hD1, 6'd3, 16'h00D0);
    step();
    drive_op(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'hE0, 32'hE1, 6'd3, 16'h00E0);
    step();
    checks++; if (is_ready_o !== 1'b0) begin errors++; $display("FAIL flush_prefull got=%0b exp=0", is_ready_o); end
    flush_i = 1'b1; ex_ready_i = 1'b1;
    drive_op(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'hF0, 32'hF1, 6'd3, 16'h00F0);
    step();
    flush_i = 1'b0; is_valid_i = 1'b0;
    checks++; if ({ex_valid_o, is_ready_o} !== 2'b01) begin errors++; $display("FAIL flush_empty got=%b%b exp=01", ex_valid_o, is_ready_o); end
    step();
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got=%0b exp=0", ex_valid_o); end
    drive_op(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'h5151, 32'h0, 6'd3, 16'h0051);
    step();
    is_valid_i = 1'b0;
    checks++; if ({ex_valid_o, ex_src0_o} !== {1'b1, 32'h5151}) begin errors++; $display("FAIL flush_resume got=%b/%h exp=1/5151", ex_valid_o, ex_src0_o); end
    step();
  endtask

  task automatic test_async_reset();
    ex_ready_i = 1'b0;
    drive_op(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'h5A, 32'h6B, 6'd4, 16'h005A);
    step();
    is_valid_i = 1'b0;
    checks++; if ({ex_valid_o, ex_src0_o} !== {1'b1, 32'h5A}) begin errors++; $display("FAIL areset_pre got=%b/%h exp=1/5a", ex_valid_o, ex_src0_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ex_valid_o, is_ready_o, ex_src0_o, ex_src1_o} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin errors++; $display("FAIL areset_immediate got=%b/%b/%h/%h exp=0/1/0/0", ex_valid_o, is_ready_o, ex_src0_o, ex_src1_o); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if ({ex_valid_o, is_ready_o, ex_oc_o} !== {1'b0, 1'b1, 16'h0}) begin errors++; $display("FAIL areset_post got=%b/%b/%h exp=0/1/0", ex_valid_o, is_ready_o, ex_oc_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
